// File: rtl/configure_pkg.sv
// System configuration: memory map regions and write buffer sizing.
package configure_pkg;

  localparam int writebuffer_depth = 4;

  // Data BRAM window; anything outside it (print, CLINT) is treated as IO.
  localparam logic [31:0] bram_base_addr = 32'h0000_0000;
  localparam logic [31:0] bram_top_addr  = 32'h0100_0000;

endpackage

// File: rtl/writebuffer_pkg.sv
// Shared types and address decode for the posted-write buffer.
package writebuffer_pkg;

  import configure_pkg::*;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } writebuffer_entry_type;

  typedef enum logic {
    F_IDLE,
    F_HOLD
  } front_state_type;

  typedef enum logic [1:0] {
    M_IDLE,
    M_DRAIN,
    M_PASS
  } mem_state_type;

  // Offset compare keeps the range check a single unsigned comparison.
  function automatic logic is_buffered(input logic [31:0] addr);
    return (addr - bram_base_addr) < (bram_top_addr - bram_base_addr);
  endfunction

endpackage

// File: rtl/writebuffer_fifo.sv
// Circular store queue with a parallel word-address hazard compare.
module writebuffer_fifo
  import writebuffer_pkg::*;
#(
  parameter int depth = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  writebuffer_entry_type    push_entry,
  input  logic                     pop,
  input  logic [29:0]              cmp_word,
  output writebuffer_entry_type    head_entry,
  output logic [$clog2(depth):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     match
);

  localparam int pw = $clog2(depth);

  writebuffer_entry_type entries [depth];
  logic [pw-1:0]         head_ptr;
  logic [pw-1:0]         tail_ptr;

  // Pointer and occupancy bookkeeping; push and pop together leave count unchanged.
  always_ff @(posedge clock) begin
    if (!reset) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (push) tail_ptr <= tail_ptr + 1'b1;
      if (pop)  head_ptr <= head_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Entry storage; the slot freed by a same-cycle pop can be refilled at once
  // because the memory port already holds a registered copy of the head.
  always_ff @(posedge clock) begin
    if (push) entries[tail_ptr] <= push_entry;
  end

  // An entry is live when its distance from head is below count.
  always_comb begin
    match = 1'b0;
    for (int i = 0; i < depth; i++) begin
      if (({1'b0, pw'(i) - head_ptr} < count) && (entries[i].addr[31:2] == cmp_word))
        match = 1'b1;
    end
  end

  assign head_entry = entries[head_ptr];
  assign full       = (count == (pw + 1)'(depth));
  assign empty      = (count == '0);

endmodule

// File: rtl/writebuffer.sv
// Posted-write buffer between the core data port and the memory bus.
// Handshakes: wb_valid is a one-cycle request strobe and wb_ready a one-cycle
// completion pulse (no new request before it); mem_valid is held with stable
// address/data until the one-cycle mem_ready pulse, which is only honoured
// while mem_valid is high.
module writebuffer
  import configure_pkg::*;
  import writebuffer_pkg::*;
#(
  parameter int depth = writebuffer_depth
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        wb_valid,
  input  logic [31:0] wb_addr,
  input  logic [31:0] wb_wdata,
  input  logic [3:0]  wb_wstrb,
  output logic [31:0] wb_rdata,
  output logic        wb_ready,
  output logic        wb_idle,
  output logic        mem_valid,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  localparam int pw = $clog2(depth);

  front_state_type       front_state, front_next;
  mem_state_type         mem_state, mem_next;
  writebuffer_entry_type held_req, cur_req, head_entry;
  logic [pw:0]           count, count_next;
  logic                  full, empty, hazard;
  logic                  cur_valid, cur_store, cur_buffered;
  logic                  push, pop, pass_go, drain_go;

  writebuffer_fifo #(.depth(depth)) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .push       (push),
    .push_entry (cur_req),
    .pop        (pop),
    .cmp_word   (cur_req.addr[31:2]),
    .head_entry (head_entry),
    .count      (count),
    .full       (full),
    .empty      (empty),
    .match      (hazard)
  );

  // Resolve the current request (fresh strobe or held) and arbitrate the port.
  always_comb begin
    cur_valid    = wb_valid || (front_state == F_HOLD);
    cur_req      = wb_valid ? '{addr: wb_addr, wdata: wb_wdata, wstrb: wb_wstrb} : held_req;
    cur_store    = (cur_req.wstrb != 4'h0);
    cur_buffered = cur_store && is_buffered(cur_req.addr);
    pop          = (mem_state == M_DRAIN) && mem_ready;
    push         = cur_valid && cur_buffered && (!full || pop);
    pass_go      = cur_valid && !cur_buffered && (mem_state == M_IDLE) &&
                   (cur_store ? empty : !hazard);
    drain_go     = (mem_state == M_IDLE) && !empty && !pass_go;

    front_next = (cur_valid && !push && !pass_go) ? F_HOLD : F_IDLE;

    mem_next = mem_state;
    case (mem_state)
      M_IDLE:  if (pass_go) mem_next = M_PASS;
               else if (drain_go) mem_next = M_DRAIN;
      M_DRAIN: if (mem_ready) mem_next = M_IDLE;
      M_PASS:  if (mem_ready) mem_next = M_IDLE;
      default: mem_next = M_IDLE;
    endcase

    count_next = count;
    if (push && !pop)      count_next = count + 1'b1;
    else if (pop && !push) count_next = count - 1'b1;
  end

  // Front FSM: capture every strobe and keep it until pushed or issued.
  always_ff @(posedge clock) begin
    if (!reset) begin
      front_state <= F_IDLE;
      held_req    <= '0;
    end else begin
      front_state <= front_next;
      if (wb_valid) held_req <= cur_req;
    end
  end

  // Memory-port FSM: launch pass-through or head drain, hold until mem_ready.
  always_ff @(posedge clock) begin
    if (!reset) begin
      mem_state <= M_IDLE;
      mem_valid <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      wb_rdata  <= '0;
    end else begin
      mem_state <= mem_next;
      if (pass_go) begin
        mem_valid <= 1'b1;
        mem_addr  <= cur_req.addr;
        mem_wdata <= cur_req.wdata;
        mem_wstrb <= cur_req.wstrb;
      end else if (drain_go) begin
        mem_valid <= 1'b1;
        mem_addr  <= head_entry.addr;
        mem_wdata <= head_entry.wdata;
        mem_wstrb <= head_entry.wstrb;
      end else if ((mem_state != M_IDLE) && mem_ready) begin
        mem_valid <= 1'b0;
      end
      if ((mem_state == M_PASS) && mem_ready) wb_rdata <= mem_rdata;
    end
  end

  // Completion pulse and fence status, both registered from next-state values.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wb_ready <= 1'b0;
      wb_idle  <= 1'b1;
    end else begin
      wb_ready <= push || ((mem_state == M_PASS) && mem_ready);
      wb_idle  <= (count_next == '0) && (front_next == F_IDLE) && (mem_next == M_IDLE);
    end
  end

endmodule
